// File: rtl/hd44780_nibble_responder.sv
// HD44780-style character LCD responder: decodes 8/4-bit nibble transfers on the
// bit-banged bus, executes the instruction subset and holds a 128-byte DDRAM.
module hd44780_nibble_responder #(
  parameter int unsigned BUSY_CYCLES       = 2000,
  parameter int unsigned CLEAR_BUSY_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lcd_data_in,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [3:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] disp_rd_addr,
  output logic [7:0] disp_rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       busy,
  output logic       four_bit_mode,
  output logic       cmd_strobe,
  output logic       data_strobe,
  output logic [7:0] rx_byte,
  output logic       protocol_error
);

  logic [7:0]  ddram [128];
  logic        en_q;
  logic        rs_q;
  logic        rw_q;
  logic [3:0]  data_q;
  logic        phase_r;
  logic [3:0]  hi_r;
  logic        id_r;
  logic [31:0] busy_cnt_r;
  logic        clr_active_r;
  logic [6:0]  clr_addr_r;

  logic        fall_s;
  logic        wr_fall_s;
  logic        last_nib_s;
  logic [7:0]  byte_s;
  logic        exec_s;
  logic        is_clear_s;
  logic        rd_ac_move_s;
  logic        rd_phase_s;
  logic [7:0]  mem_at_ac_s;
  logic [3:0]  rd_nib_s;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    return inc ? (a + 7'd1) : (a - 7'd1);
  endfunction

  // Transfer decode from the registered bus sample
  always_comb begin
    fall_s       = en_q & ~lcd_en;
    wr_fall_s    = fall_s & ~rw_q;
    last_nib_s   = four_bit_mode ? phase_r : 1'b1;
    byte_s       = four_bit_mode ? {hi_r, data_q} : {data_q, 4'h0};
    // an all-zero instruction byte is a no-op and does not start busy
    exec_s       = wr_fall_s & last_nib_s & ~busy & (rs_q | (byte_s != 8'h00));
    is_clear_s   = ~rs_q & (byte_s == 8'h01);
    rd_ac_move_s = fall_s & rw_q & rs_q & last_nib_s & ~busy;
    rd_phase_s   = four_bit_mode ? phase_r : 1'b0;
    mem_at_ac_s  = ddram[cursor_addr];
    if (rs_q) begin
      rd_nib_s = rd_phase_s ? mem_at_ac_s[3:0] : mem_at_ac_s[7:4];
    end else begin
      rd_nib_s = rd_phase_s ? cursor_addr[3:0] : {busy, cursor_addr[6:4]};
    end
  end

  // Control state, busy timing, strobes and read-bus drive
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q           <= 1'b0;
      rs_q           <= 1'b0;
      rw_q           <= 1'b0;
      data_q         <= 4'h0;
      phase_r        <= 1'b0;
      hi_r           <= 4'h0;
      id_r           <= 1'b1;
      busy_cnt_r     <= 32'd0;
      busy           <= 1'b0;
      cursor_addr    <= 7'h00;
      display_on     <= 1'b0;
      cursor_on      <= 1'b0;
      four_bit_mode  <= 1'b0;
      cmd_strobe     <= 1'b0;
      data_strobe    <= 1'b0;
      rx_byte        <= 8'h00;
      protocol_error <= 1'b0;
      lcd_data_oe    <= 1'b0;
      lcd_data_out   <= 4'h0;
      clr_active_r   <= 1'b0;
      clr_addr_r     <= 7'h00;
    end else begin
      en_q         <= lcd_en;
      rs_q         <= lcd_rs;
      rw_q         <= lcd_rw;
      data_q       <= lcd_data_in;
      cmd_strobe   <= 1'b0;
      data_strobe  <= 1'b0;
      lcd_data_oe  <= en_q & rw_q;
      lcd_data_out <= rd_nib_s;

      if (exec_s) begin
        busy       <= 1'b1;
        busy_cnt_r <= is_clear_s ? 32'(CLEAR_BUSY_CYCLES) : 32'(BUSY_CYCLES);
      end else if (busy) begin
        busy_cnt_r <= busy_cnt_r - 32'd1;
        busy       <= (busy_cnt_r != 32'd1);
      end

      if (fall_s && four_bit_mode) begin
        phase_r <= ~phase_r;
      end

      if (wr_fall_s) begin
        if (four_bit_mode && !phase_r) begin
          hi_r <= data_q;
        end
        if (busy) begin
          protocol_error <= 1'b1;
        end
      end

      if (exec_s) begin
        rx_byte <= byte_s;
        if (rs_q) begin
          data_strobe <= 1'b1;
          cursor_addr <= ac_step(cursor_addr, id_r);
        end else begin
          cmd_strobe <= 1'b1;
          casez (byte_s)
            8'b1???????: cursor_addr <= byte_s[6:0];
            8'b01??????: ;
            8'b001?????: four_bit_mode <= ~byte_s[4];
            8'b0001????: begin
              if (!byte_s[3]) begin
                cursor_addr <= ac_step(cursor_addr, byte_s[2]);
              end
            end
            8'b00001???: begin
              display_on <= byte_s[2];
              cursor_on  <= byte_s[1];
            end
            8'b000001??: id_r <= byte_s[1];
            8'b0000001?: cursor_addr <= 7'h00;
            8'b00000001: begin
              cursor_addr  <= 7'h00;
              id_r         <= 1'b1;
              clr_active_r <= 1'b1;
              clr_addr_r   <= 7'h00;
            end
            default: ;
          endcase
        end
      end else if (rd_ac_move_s) begin
        cursor_addr <= ac_step(cursor_addr, id_r);
      end

      if (clr_active_r) begin
        clr_addr_r <= clr_addr_r + 7'd1;
        if (clr_addr_r == 7'h7F) begin
          clr_active_r <= 1'b0;
        end
      end
    end
  end

  // DDRAM write port (clear sweep or data write) and overlay read port
  always_ff @(posedge clk) begin
    if (clr_active_r) begin
      ddram[clr_addr_r] <= 8'h20;
    end else if (exec_s && rs_q) begin
      ddram[cursor_addr] <= byte_s;
    end
    disp_rd_data <= ddram[disp_rd_addr];
  end

endmodule

// File: tb/tb_hd44780_nibble_responder.sv
// Scoreboard bench for hd44780_nibble_responder: expected strobes are queued by
// the stimulus and popped by an independent monitor; state is checked directly.
module tb_hd44780_nibble_responder;
  localparam int BC  = 20;
  localparam int CBC = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lcd_data_in;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [3:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [6:0] disp_rd_addr;
  logic [7:0] disp_rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, busy, four_bit_mode;
  logic       cmd_strobe, data_strobe, protocol_error;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_data;
    logic [7:0] b;
  } exp_t;
  exp_t exp_q[$];

  hd44780_nibble_responder #(.BUSY_CYCLES(BC), .CLEAR_BUSY_CYCLES(CBC)) dut (
    .clk(clk), .rst(rst), .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data_out(lcd_data_out),
    .lcd_data_oe(lcd_data_oe), .disp_rd_addr(disp_rd_addr),
    .disp_rd_data(disp_rd_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .busy(busy),
    .four_bit_mode(four_bit_mode), .cmd_strobe(cmd_strobe),
    .data_strobe(data_strobe), .rx_byte(rx_byte),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (cmd_strobe || data_strobe)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got data=%0b byte=%h, expected none", data_strobe, rx_byte);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({data_strobe, cmd_strobe, rx_byte} !== {e.is_data, ~e.is_data, e.b}) begin
          errors++;
          $display("FAIL strobe: got data=%0b cmd=%0b byte=%h, expected data=%0b byte=%h",
                   data_strobe, cmd_strobe, rx_byte, e.is_data, e.b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write nibble; returns just after the falling-edge transfer registers
  task automatic nib(input logic rs, input logic [3:0] d);
    tick();
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
    tick();
    tick();
    lcd_en = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic rs, input logic [7:0] b, input logic expect_exec);
    if (expect_exec) exp_q.push_back('{is_data: rs, b: b});
    nib(rs, b[7:4]);
    nib(rs, b[3:0]);
  endtask

  task automatic rd_nib(input string name, input logic rs, input logic [3:0] exp);
    tick();
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    tick();
    tick();
    check(name, lcd_data_out, exp);
    check({name, "_oe_hi"}, lcd_data_oe, 1);
    lcd_en = 1'b0;
    tick();
    lcd_rw = 1'b0;
    tick();
    check({name, "_oe_lo"}, lcd_data_oe, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic measure_busy(input string name, input int exp);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check(name, n, exp);
  endtask

  task automatic check_mem(input string name, input logic [6:0] a, input logic [7:0] exp);
    disp_rd_addr = a;
    tick();
    check(name, disp_rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data_in = 4'h0; disp_rd_addr = 7'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ac", cursor_addr, 0);
    check("rst_flags", {display_on, cursor_on, busy, four_bit_mode, protocol_error}, 0);
    check("rst_outs", {cmd_strobe, data_strobe, rx_byte, lcd_data_oe, lcd_data_out}, 0);

    // 8-bit init sequence 3,3,3,2
    exp_q.push_back('{is_data: 1'b0, b: 8'h30}); nib(1'b0, 4'h3);
    check("busy_after_exec", busy, 1);
    wait_idle();
    exp_q.push_back('{is_data: 1'b0, b: 8'h30}); nib(1'b0, 4'h3); wait_idle();
    exp_q.push_back('{is_data: 1'b0, b: 8'h30}); nib(1'b0, 4'h3); wait_idle();
    check("still_8bit", four_bit_mode, 0);
    exp_q.push_back('{is_data: 1'b0, b: 8'h20}); nib(1'b0, 4'h2); wait_idle();
    check("four_bit", four_bit_mode, 1);

    // display control, entry mode, first data write
    wr_byte(1'b0, 8'h0C, 1'b1); wait_idle();
    check("disp_ctrl", {display_on, cursor_on}, 2'b10);
    wr_byte(1'b0, 8'h06, 1'b1); wait_idle();
    wr_byte(1'b1, 8'h48, 1'b1);
    measure_busy("busy_len", BC);
    check_mem("ddram0", 7'h00, 8'h48);
    check("ac_after_data", cursor_addr, 1);

    // clear display
    wr_byte(1'b0, 8'h01, 1'b1);
    measure_busy("clear_busy_len", CBC);
    check("ac_after_clear", cursor_addr, 0);
    for (int i = 0; i < 128; i++) check_mem("clear_fill", 7'(i), 8'h20);

    // busy-flag reads during and after busy at AC=0x25
    wr_byte(1'b0, 8'hA5, 1'b1);
    rd_nib("bf_busy_hi", 1'b0, 4'hA);
    rd_nib("bf_busy_lo", 1'b0, 4'h5);
    wait_idle();
    rd_nib("bf_idle_hi", 1'b0, 4'h2);
    rd_nib("bf_idle_lo", 1'b0, 4'h5);

    // data nibble written while busy
    wr_byte(1'b0, 8'hA5, 1'b1);
    nib(1'b1, 4'h5);
    check("perr_set", protocol_error, 1);
    check("perr_ac", cursor_addr, 7'h25);
    wait_idle();
    rd_nib("perr_phase", 1'b0, 4'h5);
    check_mem("perr_ddram", 7'h25, 8'h20);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("perr_rst", {protocol_error, four_bit_mode}, 0);

    // back to 4-bit, increment wrap at 0x7F
    exp_q.push_back('{is_data: 1'b0, b: 8'h20}); nib(1'b0, 4'h2); wait_idle();
    wr_byte(1'b0, 8'hFF, 1'b1); wait_idle();
    check("ac_7f", cursor_addr, 7'h7F);
    wr_byte(1'b1, 8'h41, 1'b1); wait_idle();
    check_mem("wrap_inc_mem", 7'h7F, 8'h41);
    check("wrap_inc_ac", cursor_addr, 0);

    // decrement wrap at 0x00
    wr_byte(1'b0, 8'h04, 1'b1); wait_idle();
    wr_byte(1'b1, 8'h42, 1'b1); wait_idle();
    check_mem("wrap_dec_mem", 7'h00, 8'h42);
    check("wrap_dec_ac", cursor_addr, 7'h7F);

    // data read at 0x7F with decrement
    rd_nib("drd_hi", 1'b1, 4'h4);
    check("drd_ac_hold", cursor_addr, 7'h7F);
    rd_nib("drd_lo", 1'b1, 4'h1);
    check("drd_ac_move", cursor_addr, 7'h7E);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
